// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// responder state type and request legality helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    // Stores have no unsigned variants, so their legal set is smaller.
    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        if (we) return funct3 inside {F3_B, F3_H, F3_W};
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic addr_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return ~addr_lo[0];
            2'b10:   return addr_lo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core's memory stage (master) and
// the data-memory responder (slave).
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a RAM word and sign- or
// zero-extends it according to the load funct3.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0, w_half};
            F3_W:    o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_CYCLES wait states,
// byte-lane RAM writes and registered, formatted load responses.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    resp_state_t      r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic             r_we;
    logic [2:0]       r_funct3;
    logic [AW+1:0]    r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [31:0]      r_ram [DEPTH_WORDS];

    logic             w_accept;
    logic             w_finish;
    logic             w_cur_we;
    logic [2:0]       w_cur_funct3;
    logic [AW+1:0]    w_cur_addr;
    logic [31:0]      w_cur_wdata;
    logic [AW-1:0]    w_word_idx;
    logic             w_legal;
    logic [3:0]       w_be;
    logic [31:0]      w_wlanes;
    logic [31:0]      w_load_data;
    logic             w_unused_addr;

    assign w_unused_addr = ^bus.req_addr[31:AW+2];
    assign w_accept      = (r_state == IDLE) && bus.req_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = RESP;
                        w_finish    = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = RESP;
                    w_finish    = 1'b1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // With zero wait states the access completes on the accept edge, so the
    // live request fields are used instead of the not-yet-latched copies.
    assign w_cur_we     = (r_state == IDLE) ? bus.req_we           : r_we;
    assign w_cur_funct3 = (r_state == IDLE) ? bus.req_funct3       : r_funct3;
    assign w_cur_addr   = (r_state == IDLE) ? bus.req_addr[AW+1:0] : r_addr;
    assign w_cur_wdata  = (r_state == IDLE) ? bus.req_wdata        : r_wdata;
    assign w_word_idx   = w_cur_addr[AW+1:2];
    assign w_legal      = f3_legal(w_cur_we, w_cur_funct3) &&
                          addr_aligned(w_cur_funct3, w_cur_addr[1:0]);

    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = w_cur_wdata;
        case (w_cur_funct3)
            F3_B: begin
                w_be     = 4'b0001 << w_cur_addr[1:0];
                w_wlanes = {4{w_cur_wdata[7:0]}};
            end
            F3_H: begin
                w_be     = w_cur_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_cur_wdata[15:0]}};
            end
            F3_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
        if (!(w_finish && w_cur_we && w_legal && reset)) w_be = 4'b0000;
    end

    // NOTE: the RAM array is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_ram[w_word_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
        end
    end

    load_align u_load_align (
        .i_word    (r_ram[w_word_idx]),
        .i_addr_lo (w_cur_addr[1:0]),
        .i_funct3  (w_cur_funct3),
        .o_data    (w_load_data)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr[AW+1:0];
                r_wdata  <= bus.req_wdata;
            end
            r_rdata <= '0;
            r_err   <= 1'b0;
            if (w_finish) begin
                r_err   <= !w_legal;
                r_rdata <= (w_legal && !w_cur_we) ? w_load_data : '0;
            end
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (1, 0 and 3 wait states)
// checked every cycle against a byte-addressed reference model.
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int N = 3;
    localparam int WC [N] = '{1, 0, 3};
    localparam int DW [N] = '{1024, 256, 64};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        d_valid [N];
    logic        d_we    [N];
    logic [2:0]  d_f3    [N];
    logic [31:0] d_addr  [N];
    logic [31:0] d_wdata [N];
    logic        o_ready [N];
    logic        o_valid [N];
    logic [31:0] o_rdata [N];
    logic        o_err   [N];

    data_mem_responder_if bus [N] ();

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign bus[g].req_valid  = d_valid[g];
        assign bus[g].req_we     = d_we[g];
        assign bus[g].req_funct3 = d_f3[g];
        assign bus[g].req_addr   = d_addr[g];
        assign bus[g].req_wdata  = d_wdata[g];
        assign o_ready[g] = bus[g].req_ready;
        assign o_valid[g] = bus[g].rsp_valid;
        assign o_rdata[g] = bus[g].rsp_rdata;
        assign o_err[g]   = bus[g].rsp_err;

        data_mem_responder #(.DEPTH_WORDS(DW[g]), .WAIT_CYCLES(WC[g])) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus[g])
        );
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out waiting on the DUT", name);
    endtask

    // Reference model: byte-addressed memory, request tracked by edges since accept.
    bit [7:0]    mm [N][4096];
    bit          m_pend [N] = '{default: 1'b0};
    int          m_t    [N] = '{default: 0};
    logic        m_we   [N];
    logic [2:0]  m_f3   [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_wd   [N];
    logic        e_valid [N] = '{default: 1'b0};
    logic [31:0] e_rdata [N] = '{default: 32'h0};
    logic        e_err   [N] = '{default: 1'b0};

    task automatic model_resp(input int k);
        int b;
        logic ok;
        logic [2:0] f;
        f  = m_f3[k];
        b  = int'(m_addr[k] % 32'(DW[k] * 4));
        ok = 1'b1;
        if (m_we[k] && !(f == 0 || f == 1 || f == 2)) ok = 1'b0;
        if (!m_we[k] && !(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) ok = 1'b0;
        if ((f == 1 || f == 5) && (b % 2) != 0) ok = 1'b0;
        if (f == 2 && (b % 4) != 0) ok = 1'b0;
        e_valid[k] = 1'b1;
        e_err[k]   = !ok;
        e_rdata[k] = 32'h0;
        if (ok && m_we[k]) begin
            for (int i = 0; i < (1 << f); i++) mm[k][b+i] = m_wd[k][8*i +: 8];
        end else if (ok) begin
            case (f)
                3'd0: e_rdata[k] = 32'($signed(mm[k][b]));
                3'd4: e_rdata[k] = {24'h0, mm[k][b]};
                3'd1: e_rdata[k] = 32'($signed({mm[k][b+1], mm[k][b]}));
                3'd5: e_rdata[k] = {16'h0, mm[k][b+1], mm[k][b]};
                default: e_rdata[k] = {mm[k][b+3], mm[k][b+2], mm[k][b+1], mm[k][b]};
            endcase
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            e_valid[k] = 1'b0;
            e_rdata[k] = 32'h0;
            e_err[k]   = 1'b0;
            if (!reset) begin
                m_pend[k] = 1'b0;
            end else if (m_pend[k]) begin
                m_t[k]++;
                if (m_t[k] == WC[k]) model_resp(k);
                else if (m_t[k] == WC[k] + 1) m_pend[k] = 1'b0;
            end else if (d_valid[k]) begin
                m_pend[k] = 1'b1;
                m_t[k]    = 0;
                m_we[k]   = d_we[k];
                m_f3[k]   = d_f3[k];
                m_addr[k] = d_addr[k];
                m_wd[k]   = d_wdata[k];
                if (WC[k] == 0) model_resp(k);
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            check($sformatf("dut%0d req_ready", k), 32'(o_ready[k]), 32'(!m_pend[k]));
            check($sformatf("dut%0d rsp_valid", k), 32'(o_valid[k]), 32'(e_valid[k]));
            check($sformatf("dut%0d rsp_rdata", k), o_rdata[k], e_rdata[k]);
            check($sformatf("dut%0d rsp_err", k), 32'(o_err[k]), 32'(e_err[k]));
        end
    end

    task automatic do_req(input int k, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
        int n;
        @(negedge clk); #1;
        d_valid[k] = 1'b1;
        d_we[k]    = we;
        d_f3[k]    = f3;
        d_addr[k]  = addr;
        d_wdata[k] = wd;
        n = 0;
        while (!o_ready[k] && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        d_valid[k] = 1'b0;
        rd  = 32'h0;
        err = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_valid[k] && lat < 50);
        if (!o_valid[k]) timeout($sformatf("dut%0d rsp_valid", k));
        else begin
            rd  = o_rdata[k];
            err = o_err[k];
        end
    endtask

    task automatic req_chk(input string name, input int k, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic err;
        int lat;
        do_req(k, we, f3, addr, wd, rd, err, lat);
        check({name, " rdata"}, rd, exp_rd);
        check({name, " err"}, 32'(err), 32'(exp_err));
        check({name, " latency"}, 32'(lat), 32'(WC[k] + 1));
    endtask

    // Holds req_valid high for n pre-edge samples and counts how many would accept.
    task automatic hold_count(input int k, input logic [31:0] addr, input int n, output int acc);
        @(negedge clk); #1;
        d_valid[k] = 1'b1;
        d_we[k]    = 1'b0;
        d_f3[k]    = F3_W;
        d_addr[k]  = addr;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            if (o_ready[k]) acc++;
            @(negedge clk); #1;
        end
        d_valid[k] = 1'b0;
        repeat (WC[k] + 3) @(negedge clk);
    endtask

    initial begin
        int acc;
        int seen;
        for (int k = 0; k < N; k++) begin
            d_valid[k] = 1'b0;
            d_we[k]    = 1'b0;
            d_f3[k]    = 3'b0;
            d_addr[k]  = 32'h0;
            d_wdata[k] = 32'h0;
        end
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(o_ready[0]), 32'h1);
        check("reset rsp_valid", 32'(o_valid[0]), 32'h0);
        check("reset rsp_rdata", o_rdata[0], 32'h0);
        check("reset rsp_err", 32'(o_err[0]), 32'h0);
        #1 reset = 1'b1;

        // One wait state.
        req_chk("sw 0x10",  0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        req_chk("lw 0x10",  0, 1'b0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        req_chk("sb 0x13",  0, 1'b1, F3_B,  32'h13, 32'h00000080, 32'h0, 1'b0);
        req_chk("lb 0x13",  0, 1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        req_chk("lbu 0x13", 0, 1'b0, F3_BU, 32'h13, 32'h0, 32'h00000080, 1'b0);
        req_chk("lh 0x12",  0, 1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF80AD, 1'b0);
        req_chk("sb restore", 0, 1'b1, F3_B, 32'h13, 32'h000000DE, 32'h0, 1'b0);
        req_chk("lw 0x11 misaligned", 0, 1'b0, F3_W, 32'h11, 32'h0, 32'h0, 1'b1);
        req_chk("sh 0x03 misaligned", 0, 1'b1, F3_H, 32'h03, 32'h00001234, 32'h0, 1'b1);
        req_chk("store f3=011", 0, 1'b1, 3'b011, 32'h10, 32'h12345678, 32'h0, 1'b1);
        req_chk("lw after errors", 0, 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        hold_count(0, 32'h10, 12, acc);
        check("dut0 accepts in 12 cycles", 32'(acc), 32'(12 / (WC[0] + 2)));
        req_chk("sw wrap", 0, 1'b1, F3_W, 32'(DW[0] * 4) + 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
        req_chk("lw alias", 0, 1'b0, F3_W, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
        req_chk("lhu 0x12", 0, 1'b0, F3_HU, 32'h12, 32'h0, 32'h0000CAFE, 1'b0);

        // Zero wait states.
        req_chk("w0 sw 0x20",  1, 1'b1, F3_W,  32'h20, 32'h11223344, 32'h0, 1'b0);
        req_chk("w0 sh 0x22",  1, 1'b1, F3_H,  32'h22, 32'h0000BEEF, 32'h0, 1'b0);
        req_chk("w0 lw 0x20",  1, 1'b0, F3_W,  32'h20, 32'h0, 32'hBEEF3344, 1'b0);
        req_chk("w0 lh 0x22",  1, 1'b0, F3_H,  32'h22, 32'h0, 32'hFFFFBEEF, 1'b0);
        req_chk("w0 lhu 0x22", 1, 1'b0, F3_HU, 32'h22, 32'h0, 32'h0000BEEF, 1'b0);
        req_chk("w0 lb 0x21",  1, 1'b0, F3_B,  32'h21, 32'h0, 32'h00000033, 1'b0);
        req_chk("w0 load f3=011", 1, 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1);
        req_chk("w0 store f3=110", 1, 1'b1, 3'b110, 32'h20, 32'h0, 32'h0, 1'b1);
        hold_count(1, 32'h20, 10, acc);
        check("dut1 accepts in 10 cycles", 32'(acc), 32'(10 / (WC[1] + 2)));

        // Three wait states, reset during WAIT drops the pending store.
        req_chk("w3 sw 0x08", 2, 1'b1, F3_W, 32'h08, 32'h01020304, 32'h0, 1'b0);
        @(negedge clk); #1;
        d_valid[2] = 1'b1;
        d_we[2]    = 1'b1;
        d_f3[2]    = F3_W;
        d_addr[2]  = 32'h08;
        d_wdata[2] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        d_valid[2] = 1'b0;
        check("w3 busy after accept", 32'(o_ready[2]), 32'h0);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check("w3 ready during reset", 32'(o_ready[2]), 32'h1);
        check("w3 valid during reset", 32'(o_valid[2]), 32'h0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_valid[2]) seen++;
        end
        check("w3 no response after reset", 32'(seen), 32'h0);
        req_chk("w3 lw after reset", 2, 1'b0, F3_W, 32'h08, 32'h0, 32'h01020304, 1'b0);
        req_chk("w3 lw wrap", 2, 1'b0, F3_W, 32'(DW[2] * 4) + 32'h08, 32'h0, 32'h01020304, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
